// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, fixed WIDTH+1 cycle latency.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  // Operand conditioning at launch: op[0]=0 selects the signed variants.
  logic             sgn_op_c;
  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;

  always_comb begin
    sgn_op_c = ~op[0];
    sa_c     = sgn_op_c & A[WIDTH-1];
    sb_c     = sgn_op_c & B[WIDTH-1];
    abs_a_c  = sa_c ? WIDTH'(-A) : A;
    abs_b_c  = sb_c ? WIDTH'(-B) : B;
  end

  // One iteration: acc is {partial product, multiplier} or {remainder, quotient}.
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH:0]     rem_sh_c;
  logic [WIDTH-1:0]   rem_diff_c;
  logic               div_ge_c;
  logic [2*WIDTH-1:0] acc_step_c;

  always_comb begin
    mul_sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh_c   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge_c   = rem_sh_c >= {1'b0, opnd};
    rem_diff_c = rem_sh_c[WIDTH-1:0] - opnd;
    if (is_div)
      acc_step_c = {(div_ge_c ? rem_diff_c : rem_sh_c[WIDTH-1:0]), acc[WIDTH-2:0], div_ge_c};
    else
      acc_step_c = {mul_sum_c, acc[WIDTH-1:1]};
  end

  // Sign correction; a zero divisor leaves the remainder equal to A by construction.
  logic [2*WIDTH-1:0] prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;

  always_comb begin
    prod_fix_c = (sign_a ^ sign_b) ? (2*WIDTH)'(-acc) : acc;
    if (div_zero)
      quo_fix_c = {WIDTH{1'b1}};
    else
      quo_fix_c = (sign_a ^ sign_b) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix_c = sign_a ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div   <= op[1];
            sign_a   <= sa_c;
            sign_b   <= sb_c;
            div_zero <= op[1] && (B == '0);
            opnd     <= op[1] ? abs_b_c : abs_a_c;
            acc      <= {WIDTH'(0), (op[1] ? abs_a_c : abs_b_c)};
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_step_c;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix_c;
            lo <= quo_fix_c;
          end else begin
            hi <= prod_fix_c[2*WIDTH-1:WIDTH];
            lo <= prod_fix_c[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_mdu_iterative;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .A(a_i), .B(b_i),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // MIPS semantics expressed with plain 64-bit arithmetic.
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    longint       sp;
    logic [63:0]  up;
    int           sq;
    int           sr;
    case (op)
      2'b00: begin
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = 64'(sp);
        rhi = up[63:32];
        rlo = up[31:0];
      end
      2'b01: begin
        up  = {32'd0, a} * {32'd0, b};
        rhi = up[63:32];
        rlo = up[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          rlo = '1;
          rhi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rlo = 32'h8000_0000;
          rhi = 32'h0;
        end else begin
          sq  = $signed(a) / $signed(b);
          sr  = $signed(a) % $signed(b);
          rlo = 32'(sq);
          rhi = 32'(sr);
        end
      end
      default: begin
        if (b == 0) begin
          rlo = '1;
          rhi = a;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
  endfunction

  // Called at posedge+1; launches op, optionally disturbs it mid-flight or MTLOs at launch.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject, input bit mt);
    logic [W-1:0] ehi, elo, phi, plo;
    int lat, busy_n;
    bit hold_ok;
    ref_model(op, a, b, ehi, elo);
    op_i = op; a_i = a; b_i = b; start = 1'b1;
    if (mt) begin lo_we = 1'b1; wdata = 32'hCAFE; end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_clear_after_start", {31'd0, done}, 32'd0);
    if (mt) begin
      lo_we = 1'b0;
      check("mtlo_with_start", lo, 32'hCAFE);
    end
    phi = hi; plo = lo;
    lat = 0; busy_n = 0; hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      if (hi !== phi || lo !== plo) hold_ok = 1'b0;
      if (inject && k == 5) begin
        start = 1'b1; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        lo_we = 1'b1; hi_we = 1'b1; wdata = $urandom;
      end
      if (inject && k == 6) begin
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check("latency", 32'(lat), 32'd33);
    check("busy_cycles", 32'(busy_n), 32'd33);
    check("hold_while_busy", {31'd0, hold_ok}, 32'd1);
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    check("hi", hi, ehi);
    check("lo", lo, elo);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 20));
      4: v = 32'(-$signed(32'($urandom_range(1, 20))));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'h1234);
    check("mthi_lo_untouched", lo, 32'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("mult_neg3x5_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg3x5_lo", lo, 32'hFFFF_FFF1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_7_lo", lo, 32'd14);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("div_7_m2_hi", hi, 32'd1);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    check("div_by_zero_lo", lo, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    run_op(2'b11, 32'd9, 32'd2, 1'b1, 1'b0);
    check("divu_9_2_ignored_lo", lo, 32'd4);
    check("divu_9_2_ignored_hi", hi, 32'd1);
    run_op(2'b01, 32'd3, 32'd11, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick_operand(), pick_operand(), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Abort a MULT partway through with reset.
    op_i = 2'b00; a_i = 32'd7; b_i = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("no_activity_after_abort", 32'(seen), 32'd0);
    check("abort_hi_kept", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
